// File: rtl/sequencer_adc_sample_capture_if.sv
// -----------------------------------------------------------------------------
// sequencer_adc_sample_capture_if
// Avalon-ST response stream from the ADC sequencer core. The stream has no
// backpressure, so every beat with rsp_valid=1 is consumed by the receiver.
//   rsp_valid    beat valid
//   rsp_channel  physical ADC channel of the beat
//   rsp_data     raw 12-bit ADC code
//   rsp_sop      first beat of a scan
//   rsp_eop      last beat of a scan
// Modports: master (sequencer side, drives), slave (capture side, receives).
// -----------------------------------------------------------------------------
interface sequencer_adc_sample_capture_if;
    logic        rsp_valid;
    logic [4:0]  rsp_channel;
    logic [11:0] rsp_data;
    logic        rsp_sop;
    logic        rsp_eop;

    modport master (
        output rsp_valid, rsp_channel, rsp_data, rsp_sop, rsp_eop
    );

    modport slave (
        input rsp_valid, rsp_channel, rsp_data, rsp_sop, rsp_eop
    );
endinterface

// File: rtl/sequencer_adc_sample_capture.sv
// -----------------------------------------------------------------------------
// sequencer_adc_sample_capture
// Maps physical ADC channels onto logical rails (0 = VIN, 1..VRAILS = VOUT),
// holds the latest level per rail, and flags rails whose samples stop arriving.
//
// Ports:
//   clock, reset_n   system clock, asynchronous active-low reset
//   rsp              ADC response stream (slave modport)
//   clear_err        clears the sticky stale_err flag
//   vrail_level      published levels, rail i at [12*i +: 12]
//   vrail_update     one-cycle pulse per rail when its level is republished
//   vrail_valid      rail published and not stale
//   scan_done        one-cycle pulse after an eop beat
//   stale_err        sticky; a valid rail went stale
//
// Optional feature macro: ADC_AVERAGE_EN -- when defined, each rail publishes
// the average of every four accepted samples instead of each raw sample.
// -----------------------------------------------------------------------------
module sequencer_adc_sample_capture #(
    parameter int VRAILS       = 6,
    parameter int ADC_CHANS    = 17,
    parameter int ADC_CHAN_MAP [0:ADC_CHANS-1] =
        '{199, 0, 1, 2, 3, 4, 5, 199, 6, 199, 199, 199, 199, 199, 199, 199, 199},
    parameter int STALE_CYCLES = 100000
) (
    input  logic                       clock,
    input  logic                       reset_n,
    sequencer_adc_sample_capture_if.slave rsp,
    input  logic                       clear_err,
    output logic [12*(VRAILS+1)-1:0]   vrail_level,
    output logic [VRAILS:0]            vrail_update,
    output logic [VRAILS:0]            vrail_valid,
    output logic                       scan_done,
    output logic                       stale_err
);

    localparam int DATA_W = 12;
    localparam int NR     = VRAILS + 1;
    localparam int CNT_W  = $clog2(STALE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STALE_CYCLES);
    // Count value one edge before expiry; the expiring edge is the one that
    // would move the counter from here to CNT_MAX.
    localparam logic [CNT_W-1:0] CNT_PRE = CNT_W'(STALE_CYCLES - 1);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (c == CNT_MAX) ? c : c + 1'b1;
    endfunction

`ifdef ADC_AVERAGE_EN
    // Three 12-bit samples plus the fourth fit in 14 bits, so no overflow.
    function automatic logic [DATA_W-1:0] avg4(input logic [13:0] acc,
                                               input logic [DATA_W-1:0] d);
        logic [13:0] sum;
        sum = acc + 14'(d);
        return sum[13:2];
    endfunction

    logic [13:0] acc      [NR];
    logic [1:0]  samp_cnt [NR];
`endif

    logic [CNT_W-1:0] stale_cnt [NR];
    logic [NR-1:0]    hit_p0;
    logic [NR-1:0]    expire_p0;
    logic             err_set_p0;

    // Framing is not checked, so sop carries no information here.
    logic unused_sop;
    assign unused_sop = rsp.rsp_sop;

    // ---- stage p0: decode channel to rail, detect expiry ----
    always_comb begin
        hit_p0    = '0;
        expire_p0 = '0;
        for (int r = 0; r < NR; r++) begin
            for (int c = 0; c < ADC_CHANS; c++) begin
                if (rsp.rsp_valid && (int'(rsp.rsp_channel) == c) &&
                    (ADC_CHAN_MAP[c] == r))
                    hit_p0[r] = 1'b1;
            end
            // A beat arriving on the expiry cycle wins over the expiry.
            expire_p0[r] = !hit_p0[r] && (stale_cnt[r] == CNT_PRE);
        end
        err_set_p0 = |(expire_p0 & vrail_valid);
    end

    // ---- stage p1: registered rail state and outputs ----
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            vrail_level  <= '0;
            vrail_update <= '0;
            vrail_valid  <= '0;
            scan_done    <= 1'b0;
            stale_err    <= 1'b0;
            for (int r = 0; r < NR; r++) begin
                stale_cnt[r] <= '0;
`ifdef ADC_AVERAGE_EN
                acc[r]       <= '0;
                samp_cnt[r]  <= '0;
`endif
            end
        end else begin
            scan_done <= rsp.rsp_valid & rsp.rsp_eop;
            // A new stale event beats a simultaneous clear.
            stale_err <= err_set_p0 | (stale_err & ~clear_err);
            for (int r = 0; r < NR; r++) begin
                vrail_update[r] <= 1'b0;
                if (hit_p0[r]) begin
                    stale_cnt[r] <= '0;
`ifdef ADC_AVERAGE_EN
                    if (samp_cnt[r] == 2'd3) begin
                        vrail_level[DATA_W*r +: DATA_W] <= avg4(acc[r], rsp.rsp_data);
                        vrail_update[r] <= 1'b1;
                        vrail_valid[r]  <= 1'b1;
                        acc[r]          <= '0;
                        samp_cnt[r]     <= '0;
                    end else begin
                        acc[r]      <= acc[r] + 14'(rsp.rsp_data);
                        samp_cnt[r] <= samp_cnt[r] + 1'b1;
                    end
`else
                    vrail_level[DATA_W*r +: DATA_W] <= rsp.rsp_data;
                    vrail_update[r] <= 1'b1;
                    vrail_valid[r]  <= 1'b1;
`endif
                end else begin
                    stale_cnt[r] <= sat_inc(stale_cnt[r]);
                    if (expire_p0[r]) begin
                        vrail_valid[r] <= 1'b0;
`ifdef ADC_AVERAGE_EN
                        acc[r]         <= '0;
                        samp_cnt[r]    <= '0;
`endif
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_sequencer_adc_sample_capture.sv
module tb_sequencer_adc_sample_capture;

    logic clock;
    logic reset_n;
    logic clear_err;

    logic [83:0] def_level;
    logic [6:0]  def_update;
    logic [6:0]  def_valid;
    logic        def_scan;
    logic        def_err;

    logic [83:0] st_level;
    logic [6:0]  st_update;
    logic [6:0]  st_valid;
    logic        st_scan;
    logic        st_err;

    int vectors;
    int miscompares;

    sequencer_adc_sample_capture_if rsp_if ();

    sequencer_adc_sample_capture dut_def (
        .clock        (clock),
        .reset_n      (reset_n),
        .rsp          (rsp_if),
        .clear_err    (clear_err),
        .vrail_level  (def_level),
        .vrail_update (def_update),
        .vrail_valid  (def_valid),
        .scan_done    (def_scan),
        .stale_err    (def_err)
    );

    sequencer_adc_sample_capture #(.STALE_CYCLES(10)) dut_st (
        .clock        (clock),
        .reset_n      (reset_n),
        .rsp          (rsp_if),
        .clear_err    (clear_err),
        .vrail_level  (st_level),
        .vrail_update (st_update),
        .vrail_valid  (st_valid),
        .scan_done    (st_scan),
        .stale_err    (st_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic put_beat(input int ch, input logic [11:0] d,
                            input logic s, input logic e);
        rsp_if.rsp_valid   = 1'b1;
        rsp_if.rsp_channel = 5'(ch);
        rsp_if.rsp_data    = d;
        rsp_if.rsp_sop     = s;
        rsp_if.rsp_eop     = e;
    endtask

    task automatic put_idle();
        rsp_if.rsp_valid = 1'b0;
        rsp_if.rsp_sop   = 1'b0;
        rsp_if.rsp_eop   = 1'b0;
    endtask

    task automatic pulse_reset();
        @(negedge clock);
        put_idle();
        reset_n = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clock);
        @(negedge clock);
        vectors++;
        if ({def_level, def_update, def_valid, def_scan, def_err} !== '0) begin
            miscompares++;
            $display("FAIL reset_def: got level=%h upd=%b vld=%b scan=%b err=%b, expected all 0",
                     def_level, def_update, def_valid, def_scan, def_err);
        end
        vectors++;
        if ({st_level, st_update, st_valid, st_scan, st_err} !== '0) begin
            miscompares++;
            $display("FAIL reset_st: got level=%h upd=%b vld=%b scan=%b err=%b, expected all 0",
                     st_level, st_update, st_valid, st_scan, st_err);
        end
        reset_n = 1'b1;
    endtask

    task automatic test_first_beat();
        put_beat(1, 12'h800, 1'b0, 1'b0);
        @(negedge clock);
        put_idle();
        vectors++;
        if (def_level[11:0] !== 12'h800) begin
            miscompares++;
            $display("FAIL first_level: got %h, expected 800", def_level[11:0]);
        end
        vectors++;
        if (def_update !== 7'b0000001) begin
            miscompares++;
            $display("FAIL first_update: got %b, expected 0000001", def_update);
        end
        vectors++;
        if (def_valid !== 7'b0000001) begin
            miscompares++;
            $display("FAIL first_valid: got %b, expected 0000001", def_valid);
        end
        @(negedge clock);
        vectors++;
        if (def_update !== 7'b0) begin
            miscompares++;
            $display("FAIL first_update_clear: got %b, expected 0000000", def_update);
        end
    endtask

    task automatic test_map();
        int exp_rail [17] = '{-1, 0, 1, 2, 3, 4, 5, -1, 6, -1, -1, -1, -1, -1, -1, -1, -1};
        logic [6:0] exp_upd;
        for (int ch = 0; ch < 17; ch++) begin
            put_beat(ch, 12'(ch * 16), 1'b0, 1'b0);
            @(negedge clock);
            exp_upd = (exp_rail[ch] < 0) ? 7'b0 : (7'b1 << exp_rail[ch]);
            vectors++;
            if (def_update !== exp_upd) begin
                miscompares++;
                $display("FAIL map_update ch%0d: got %b, expected %b", ch, def_update, exp_upd);
            end
        end
        put_idle();
        @(negedge clock);
        vectors++;
        if (def_level !== {12'h080, 12'h060, 12'h050, 12'h040, 12'h030, 12'h020, 12'h010}) begin
            miscompares++;
            $display("FAIL map_levels: got %h, expected 080060050040030020010", def_level);
        end
        vectors++;
        if (def_valid !== 7'h7f) begin
            miscompares++;
            $display("FAIL map_valid: got %b, expected 1111111", def_valid);
        end
    endtask

    task automatic test_framing();
        logic exp_seq [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 6; i++) begin
            case (i)
                0: put_beat(1, 12'h111, 1'b1, 1'b0);
                1: put_beat(2, 12'h222, 1'b0, 1'b0);
                2: put_beat(16, 12'h3ff, 1'b0, 1'b1);
                4: put_beat(16, 12'h000, 1'b1, 1'b1);
                default: put_idle();
            endcase
            @(negedge clock);
            vectors++;
            if (def_scan !== exp_seq[i]) begin
                miscompares++;
                $display("FAIL framing_scan_done step%0d: got %b, expected %b", i, def_scan, exp_seq[i]);
            end
        end
        put_idle();
    endtask

    task automatic test_reset_mid();
        put_beat(3, 12'h123, 1'b0, 1'b0);
        @(posedge clock);
        #2;
        reset_n = 1'b0;
        #1;
        vectors++;
        if ({def_level, def_update, def_valid, def_scan, def_err} !== '0) begin
            miscompares++;
            $display("FAIL reset_mid_def: got level=%h upd=%b vld=%b scan=%b err=%b, expected all 0",
                     def_level, def_update, def_valid, def_scan, def_err);
        end
        vectors++;
        if ({st_level, st_update, st_valid, st_scan, st_err} !== '0) begin
            miscompares++;
            $display("FAIL reset_mid_st: got level=%h upd=%b vld=%b scan=%b err=%b, expected all 0",
                     st_level, st_update, st_valid, st_scan, st_err);
        end
        @(negedge clock);
        put_idle();
        reset_n = 1'b1;
        @(negedge clock);
        vectors++;
        if (def_valid !== 7'b0) begin
            miscompares++;
            $display("FAIL reset_mid_after: got valid %b, expected 0000000", def_valid);
        end
    endtask

    task automatic test_stale();
        logic exp_v;
        logic exp_e;
        pulse_reset();
        put_beat(3, 12'h2aa, 1'b0, 1'b0);
        @(negedge clock);
        put_idle();
        for (int k = 0; k <= 10; k++) begin
            if (k > 0) @(negedge clock);
            exp_v = (k < 10);
            exp_e = (k >= 10);
            vectors++;
            if (st_valid[2] !== exp_v || st_err !== exp_e) begin
                miscompares++;
                $display("FAIL stale_rail2 k=%0d: got valid=%b err=%b, expected valid=%b err=%b",
                         k, st_valid[2], st_err, exp_v, exp_e);
            end
        end
        put_beat(5, 12'h155, 1'b0, 1'b0);
        @(negedge clock);
        put_idle();
        for (int k = 1; k <= 9; k++) @(negedge clock);
        clear_err = 1'b1;
        @(negedge clock);
        vectors++;
        if (st_valid[4] !== 1'b0 || st_err !== 1'b1) begin
            miscompares++;
            $display("FAIL stale_clear_race: got valid4=%b err=%b, expected valid4=0 err=1",
                     st_valid[4], st_err);
        end
        @(negedge clock);
        clear_err = 1'b0;
        vectors++;
        if (st_err !== 1'b0) begin
            miscompares++;
            $display("FAIL stale_clear: got err=%b, expected 0", st_err);
        end
    endtask

    task automatic test_stale_race();
        pulse_reset();
        put_beat(3, 12'h0aa, 1'b0, 1'b0);
        @(negedge clock);
        put_idle();
        for (int k = 1; k <= 9; k++) @(negedge clock);
        put_beat(3, 12'h0bb, 1'b0, 1'b0);
        @(negedge clock);
        put_idle();
        vectors++;
        if (st_valid[2] !== 1'b1 || st_err !== 1'b0 || st_level[35:24] !== 12'h0bb) begin
            miscompares++;
            $display("FAIL stale_race: got valid2=%b err=%b level2=%h, expected valid2=1 err=0 level2=0bb",
                     st_valid[2], st_err, st_level[35:24]);
        end
        @(negedge clock);
        vectors++;
        if (st_valid[2] !== 1'b1 || st_err !== 1'b0) begin
            miscompares++;
            $display("FAIL stale_race_hold: got valid2=%b err=%b, expected valid2=1 err=0",
                     st_valid[2], st_err);
        end
    endtask

    task automatic test_average();
        logic [11:0] samples [4] = '{12'd100, 12'd101, 12'd102, 12'd105};
        pulse_reset();
        for (int i = 0; i < 4; i++) begin
            put_beat(1, samples[i], 1'b0, 1'b0);
            @(negedge clock);
            if (i < 3) begin
                vectors++;
                if (def_update !== 7'b0 || def_valid !== 7'b0) begin
                    miscompares++;
                    $display("FAIL avg_no_update s%0d: got upd=%b vld=%b, expected 0000000 0000000",
                             i, def_update, def_valid);
                end
            end
        end
        put_idle();
        vectors++;
        if (def_update !== 7'b0000001 || def_level[11:0] !== 12'd102 || def_valid[0] !== 1'b1) begin
            miscompares++;
            $display("FAIL avg_publish: got upd=%b level=%0d vld0=%b, expected 0000001 102 1",
                     def_update, def_level[11:0], def_valid[0]);
        end
        @(negedge clock);
        vectors++;
        if (def_update !== 7'b0) begin
            miscompares++;
            $display("FAIL avg_update_clear: got %b, expected 0000000", def_update);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset_n     = 1'b0;
        clear_err   = 1'b0;
        rsp_if.rsp_valid   = 1'b0;
        rsp_if.rsp_channel = '0;
        rsp_if.rsp_data    = '0;
        rsp_if.rsp_sop     = 1'b0;
        rsp_if.rsp_eop     = 1'b0;

        test_reset();
`ifndef ADC_AVERAGE_EN
        test_first_beat();
        test_map();
`endif
        test_framing();
        test_reset_mid();
`ifdef ADC_AVERAGE_EN
        test_average();
`else
        test_stale();
        test_stale_race();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
